// File: rtl/cam_search_cntrl_if.sv
// Request, CAM read and response signals of cam_search_cntrl.
// With CAM_SEARCH_MASK_EN defined, a per-request compare mask (req_mask_i) is added.
interface cam_search_cntrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] req_key_i;
  logic [ADDR_WIDTH-1:0] req_start_i;
  logic [ADDR_WIDTH-1:0] req_end_i;
`ifdef CAM_SEARCH_MASK_EN
  logic [DATA_WIDTH-1:0] req_mask_i;
`endif
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_hit_o;
  logic [ADDR_WIDTH-1:0] rsp_index_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_key_i, req_start_i, req_end_i,
`ifdef CAM_SEARCH_MASK_EN
    input  req_mask_i,
`endif
    input  rd_data_i, rsp_ready_i,
    output req_ready_o, rd_en_o, rd_addr_o,
    output rsp_valid_o, rsp_hit_o, rsp_index_o, busy_o
  );

  modport master (
    output req_valid_i, req_key_i, req_start_i, req_end_i,
`ifdef CAM_SEARCH_MASK_EN
    output req_mask_i,
`endif
    output rd_data_i, rsp_ready_i,
    input  req_ready_o, rd_en_o, rd_addr_o,
    input  rsp_valid_o, rsp_hit_o, rsp_index_o, busy_o
  );
endinterface

// File: rtl/cam_search_cntrl.sv
// Linear CAM window search: reads start..end (wrapping), reports the first matching address.
// Optional feature macro CAM_SEARCH_MASK_EN adds a per-request compare mask.
module cam_search_cntrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  cam_search_cntrl_if.slave bus,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready_o is high only in IDLE; rsp_valid_o is high only in RESP and the response
  // fields hold stable until rsp_ready_i; ready inputs seen outside those states are ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  rd_en;
  logic                  match;
  logic [ADDR_WIDTH-1:0] span;

`ifdef CAM_SEARCH_MASK_EN
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  assign match = ((bus.rd_data_i ^ key_q) & mask_q) == '0;
`else
  assign match = (bus.rd_data_i == key_q);
`endif

  // Modular distance; the window holds span+1 entries, up to the full CAM depth.
  assign span = bus.req_end_i - bus.req_start_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      key_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
`ifdef CAM_SEARCH_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      key_q       <= key_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
`ifdef CAM_SEARCH_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    key_d       = key_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    hit_d       = hit_q;
    idx_d       = idx_q;
    rd_en       = 1'b0;
`ifdef CAM_SEARCH_MASK_EN
    mask_d      = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          key_d   = bus.req_key_i;
          addr_d  = bus.req_start_i;
          rem_d   = {1'b0, span} + CNT_ONE;
`ifdef CAM_SEARCH_MASK_EN
          mask_d  = bus.req_mask_i;
`endif
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        rd_en = (rem_q != '0);
        // pend_q marks that rd_data_i carries the word read last cycle from pend_addr_q.
        if (pend_q && match) begin
          hit_d   = 1'b1;
          idx_d   = pend_addr_q;
          state_d = S_RESP;
        end else if (pend_q && (rem_q == '0)) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = S_RESP;
        end else if (rd_en) begin
          pend_d      = 1'b1;
          pend_addr_d = addr_q;
          addr_d      = addr_q + ADDR_ONE;
          rem_d       = rem_q - CNT_ONE;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_o   = addr_q;
  assign bus.rsp_valid_o = (state_q == S_RESP);
  assign bus.rsp_hit_o   = hit_q;
  assign bus.rsp_index_o = idx_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cam_search_cntrl.sv
// Self-checking bench for cam_search_cntrl: directed window cases, reset abort, random searches.
module tb_cam_search_cntrl;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] ALL = '1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_search_cntrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cam_search_cntrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] drv_mask = ALL;
`ifdef CAM_SEARCH_MASK_EN
  assign bus.req_mask_i = drv_mask;
`endif

  // CAM memory: one-cycle read latency, junk data when not reading
  always @(posedge clk) bus.rd_data_i <= bus.rd_en_o ? mem[bus.rd_addr_o] : DW'($urandom);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [AW:0]   exp_q[$];   // {hit, index} of each accepted search
  bit            m_busy = 1'b0;
  bit            m_hit;
  int            m_t, m_n, m_k, m_lat, m_last, rd_cnt;
  logic [AW-1:0] m_s;
  logic [AW-1:0] last_rd_addr;

  // Reference: window scan computed directly from start/end/key at acceptance
  task automatic model_accept();
    int s, e, a;
    logic [DW-1:0] key;
    s = int'(bus.req_start_i);
    e = int'(bus.req_end_i);
    key = bus.req_key_i;
    m_s = bus.req_start_i;
    m_t = cyc;
    m_n = ((e - s + DEPTH) % DEPTH) + 1;
    m_hit = 1'b0;
    m_k = m_n;
    for (int k = 0; k < m_n; k++) begin
      a = (s + k) % DEPTH;
      if (!m_hit && (((mem[a] ^ key) & drv_mask) == '0)) begin
        m_hit = 1'b1;
        m_k = k;
      end
    end
    m_lat  = m_hit ? 3 + m_k : 2 + m_n;
    m_last = m_hit ? m_k : m_n - 1;
    rd_cnt = 0;
    exp_q.push_back(m_hit ? {1'b1, AW'((s + m_k) % DEPTH)} : {1'b0, {AW{1'b0}}});
    m_busy = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      chk("req_ready_idle", bus.req_ready_o, 1);
      chk("busy_idle", bus.busy_o, 0);
      chk("rsp_valid_idle", bus.rsp_valid_o, 0);
      chk("rd_en_idle", bus.rd_en_o, 0);
      chk("dbg_state_idle", dbg_state == 2'd0, 1);
      if (bus.req_valid_i) model_accept();
    end else begin
      int  d, j;
      bit  resp;
      d = cyc - m_t;
      j = d - 1;
      resp = (d >= m_lat);
      chk("req_ready_busy", bus.req_ready_o, 0);
      chk("busy", bus.busy_o, 1);
      chk("rsp_valid", bus.rsp_valid_o, resp);
      if (j <= m_last) chk("rd_en_required", bus.rd_en_o, 1);
      else if (!(m_hit && j == m_k + 1 && j < m_n)) chk("rd_en_none", bus.rd_en_o, 0);
      if (bus.rd_en_o) begin
        chk("rd_addr", bus.rd_addr_o, (int'(m_s) + j) % DEPTH);
        rd_cnt++;
        last_rd_addr = bus.rd_addr_o;
      end
      if (resp && exp_q.size() > 0) begin
        chk("rsp_hit", bus.rsp_hit_o, exp_q[0][AW]);
        chk("rsp_index", bus.rsp_index_o, exp_q[0][AW-1:0]);
        if (bus.rsp_ready_i) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem_without(input logic [DW-1:0] key, input logic [DW-1:0] msk);
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      do v = DW'($urandom); while (((v ^ key) & msk) == '0);
      mem[i] = v;
    end
  endtask

  // hold: RESP cycles with rsp_ready_i low before accepting; 0 allows random ready before RESP
  task automatic search(input logic [AW-1:0] s, input logic [AW-1:0] e,
                        input logic [DW-1:0] key, input logic [DW-1:0] msk, input int hold,
                        output int lat, output bit hit, output logic [AW-1:0] idx);
    int g, t0;
    bit done;
    lat = -1; hit = 1'b0; idx = '0; done = 1'b0;
    @(posedge clk); #1;
    drv_mask = msk;
    bus.req_valid_i = 1'b1;
    bus.req_key_i   = key;
    bus.req_start_i = s;
    bus.req_end_i   = e;
    bus.rsp_ready_i = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.req_ready_o && g < 50);
    if (!bus.req_ready_o) begin
      chk("accept_timeout", 0, 1);
      bus.req_valid_i = 1'b0;
      return;
    end
    t0 = cyc;
    g = 0;
    while (!done && g < 200) begin
      @(posedge clk); #1;
      g++;
      // requests while busy must be ignored
      bus.req_valid_i = 1'($urandom_range(0, 1));
      bus.req_key_i   = DW'($urandom);
      bus.req_start_i = AW'($urandom);
      bus.req_end_i   = AW'($urandom);
      if (lat < 0) bus.rsp_ready_i = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      else         bus.rsp_ready_i = (cyc >= t0 + lat + hold);
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        if (lat < 0) begin
          lat = cyc - t0;
          hit = bus.rsp_hit_o;
          idx = bus.rsp_index_o;
        end
        if (bus.rsp_ready_i) done = 1'b1;
      end
    end
    if (!done) chk("response_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_rd_en", bus.rd_en_o, 0);
    chk("rst_rd_addr", bus.rd_addr_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_hit", bus.rsp_hit_o, 0);
    chk("rst_rsp_index", bus.rsp_index_o, 0);
    chk("rst_busy", bus.busy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  int            lat;
  bit            hit;
  logic [AW-1:0] idx;

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_key_i   = '0;
    bus.req_start_i = '0;
    bus.req_end_i   = '0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;

    // window 3..7, hit at offset 2
    fill_mem_without(32'h12, ALL);
    fill_mem_without(32'h99, ALL);
    for (int i = 0; i < 5; i++) mem[3 + i] = 32'h10 + i;
    search(5'd3, 5'd7, 32'h12, ALL, 0, lat, hit, idx);
    chk("w37_lat", lat, 5);
    chk("w37_hit", hit, 1);
    chk("w37_idx", idx, 5);
    chk("w37_reads", (rd_cnt >= 3) && (rd_cnt <= 4), 1);

    // same window, miss
    search(5'd3, 5'd7, 32'h99, ALL, 0, lat, hit, idx);
    chk("miss_lat", lat, 7);
    chk("miss_hit", hit, 0);
    chk("miss_idx", idx, 0);
    chk("miss_last_addr", last_rd_addr, 7);
    chk("miss_reads", rd_cnt, 5);

    // wrapping window 30..1, hit at address 0
    fill_mem_without(32'hAB, ALL);
    mem[0] = 32'hAB;
    search(5'd30, 5'd1, 32'hAB, ALL, 0, lat, hit, idx);
    chk("wrap_lat", lat, 5);
    chk("wrap_hit", hit, 1);
    chk("wrap_idx", idx, 0);

    // two matches, first wins; response held three cycles
    fill_mem_without(32'h55, ALL);
    mem[4] = 32'h55;
    mem[6] = 32'h55;
    search(5'd2, 5'd8, 32'h55, ALL, 3, lat, hit, idx);
    chk("first_lat", lat, 5);
    chk("first_hit", hit, 1);
    chk("first_idx", idx, 4);

    // single-entry window
    fill_mem_without(32'hC0FFEE, ALL);
    mem[9] = 32'hC0FFEE;
    search(5'd9, 5'd9, 32'hC0FFEE, ALL, 0, lat, hit, idx);
    chk("one_lat", lat, 3);
    chk("one_hit", hit, 1);
    chk("one_idx", idx, 9);

    // full-depth window, miss
    fill_mem_without(32'h5A5A, ALL);
    search(5'd0, 5'd31, 32'h5A5A, ALL, 0, lat, hit, idx);
    chk("full_lat", lat, 34);
    chk("full_hit", hit, 0);
    chk("full_reads", rd_cnt, 32);

    // reset in the middle of a scan
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    bus.req_key_i   = 32'h5A5A;
    bus.req_start_i = 5'd0;
    bus.req_end_i   = 5'd31;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifdef CAM_SEARCH_MASK_EN
    fill_mem_without(32'h1200, 32'hFF00);
    mem[2] = 32'h12AB;
    search(5'd0, 5'd5, 32'h1200, 32'hFF00, 0, lat, hit, idx);
    chk("mask_hit", hit, 1);
    chk("mask_idx", idx, 2);
    chk("mask_lat", lat, 5);
`endif

    // random searches over a small value range so hits and duplicates are common
    for (int t = 0; t < 150; t++) begin
      logic [DW-1:0] msk;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 40));
      msk = ALL;
`ifdef CAM_SEARCH_MASK_EN
      case ($urandom_range(0, 2))
        0: msk = ALL;
        1: msk = 32'h0000_000F;
        default: msk = 32'h0000_0030;
      endcase
`endif
      search(AW'($urandom), AW'($urandom), DW'($urandom_range(0, 45)), msk,
             $urandom_range(0, 3), lat, hit, idx);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cam_search_cntrl.md
CAM_SEARCH_CNTRL -- requirements
Module: cam_search_cntrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of stored tag words and search key.
REQ-002 Parameter ADDR_WIDTH, default 5, CAM address width; CAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  1  search request valid.
REQ-006 req_ready_o  out  1  block accepts request this cycle.
REQ-007 req_key_i  in  DATA_WIDTH  value to search for.
REQ-008 req_start_i  in  ADDR_WIDTH  first CAM address of the message window, inclusive.
REQ-009 req_end_i  in  ADDR_WIDTH  last CAM address of the message window, inclusive.
REQ-010 rd_en_o  out  1  CAM read strobe.
REQ-011 rd_addr_o  out  ADDR_WIDTH  CAM read address.
REQ-012 rd_data_i  in  DATA_WIDTH  CAM read data, valid exactly one cycle after rd_en_o.
REQ-013 rsp_valid_o  out  1  search result valid.
REQ-014 rsp_ready_i  in  1  consumer accepts result.
REQ-015 rsp_hit_o  out  1  1 = match found in window.
REQ-016 rsp_index_o  out  ADDR_WIDTH  address of first match; 0 on miss.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement FSM states IDLE, SCAN, RESP.
REQ-019 req_ready_o SHALL be 1 only in IDLE; a request is accepted on req_valid_i && req_ready_o, latching key, start, end; FSM enters SCAN.
REQ-020 Window length n = ((end - start) mod CAM_DEPTH) + 1; start==end is one entry; end<start wraps through CAM_DEPTH-1 to 0; n max = CAM_DEPTH.
REQ-021 In SCAN, reads SHALL issue one per cycle at start, start+1, ... (modulo CAM_DEPTH) until address end is issued; no read is issued after end.
REQ-022 Each returned word SHALL be compared in the cycle it arrives; entries are evaluated in scan order, first match wins.
REQ-023 Latency: with acceptance at cycle T, entry at offset k (0-based) is compared at T+2+k; hit -> rsp_valid_o at T+3+k; miss -> rsp_valid_o at T+2+n.
REQ-024 On hit, scanning SHALL stop immediately; an outstanding speculative read is discarded (reads have no side effects).
REQ-025 In RESP, rsp_valid_o=1 and rsp_hit_o/rsp_index_o SHALL hold stable until rsp_ready_i; on handshake FSM returns to IDLE, req_ready_o=1 next cycle.
REQ-026 rsp_ready_i asserted outside RESP SHALL be ignored; req_valid_i outside IDLE SHALL be ignored (not queued).
REQ-027 Address increment SHALL be ADDR_WIDTH-bit modular; the remaining-entry counter SHALL be ADDR_WIDTH+1 bits to represent n=CAM_DEPTH.

Reset
REQ-028 On rst, FSM SHALL go to IDLE immediately, aborting any scan or pending response without emitting it.
REQ-029 Reset values: req_ready_o=1 after release, rd_en_o=0, rd_addr_o=0, rsp_valid_o=0, rsp_hit_o=0, rsp_index_o=0, busy_o=0.
REQ-030 rd_data_i arriving in the cycle after reset release SHALL be ignored.

Configuration
REQ-031 Macro CAM_SEARCH_MASK_EN defined: input req_mask_i [DATA_WIDTH] is added, latched with the request; match = (rd_data_i & mask) == (key & mask).
REQ-032 CAM_SEARCH_MASK_EN undefined: req_mask_i port is absent; match = rd_data_i == key exactly.

Verification
REQ-033 mem[3..7]=0x10..0x14, start=3 end=7 key=0x12, accepted T -> rsp at T+5, hit=1, index=5; rd_addr 3,4,5 only plus at most one discarded read.
REQ-034 Same window, key=0x99 -> rsp at T+7, hit=0, index=0; last rd_addr=7.
REQ-035 start=30 end=1, mem[0]=0xAB, key=0xAB -> rd_addr 30,31,0; rsp at T+5, hit=1, index=0.
REQ-036 mem[4]=mem[6]=0x55, start=2 end=8, key=0x55 -> hit=1 index=4; hold rsp_ready_i=0 for 3 cycles -> outputs stable, req_ready_o=0 throughout.
REQ-037 start=end=9, mem[9]=key -> rsp at T+3 hit=1 index=9; start=0 end=31 key absent -> 32 reads, rsp at T+34 hit=0.
REQ-038 rst pulsed mid-SCAN -> all outputs at reset values immediately, no rsp_valid_o; with CAM_SEARCH_MASK_EN, mask=0xFF00, key=0x1200, mem[2]=0x12AB -> hit, index=2.
